// File: rtl/mem_router_if.sv
// Bus bundle between the E/M pipeline boundary and mem_router.
// It covers the E-stage inputs, the memory steering and select outputs, the MMIO port and the fault/stall status.
interface mem_router_if #(
  parameter int ADDR_W = 32,
  parameter int STRB_W = 4
);
  logic [ADDR_W-1:0] pc_e;
  logic [ADDR_W-1:0] data_adr_e;
  logic [STRB_W-1:0] wea;
  logic              rd_e;
  logic [STRB_W-1:0] iwea;
  logic [STRB_W-1:0] dwea;
  logic              iload_sel;
  logic [1:0]        dload_sel;
  // MMIO handshake: io_req rises with io_adr/io_we and stays high, with the
  // payload stable, until io_ack is sampled high on a clock edge (or a timeout).
  // io_ack is a one-cycle completion strobe and is ignored while io_req is low.
  logic              io_req;
  logic [STRB_W-1:0] io_we;
  logic [ADDR_W-1:0] io_adr;
  logic              io_ack;
  logic              stall;
  logic              fault;
  logic [1:0]        fault_cause;
  logic              fault_clr;

  modport master (
    output pc_e, data_adr_e, wea, rd_e, io_ack, fault_clr,
    input  iwea, dwea, iload_sel, dload_sel, io_req, io_we, io_adr,
           stall, fault, fault_cause
  );

  modport slave (
    input  pc_e, data_adr_e, wea, rd_e, io_ack, fault_clr,
    output iwea, dwea, iload_sel, dload_sel, io_req, io_we, io_adr,
           stall, fault, fault_cause
  );
endinterface

// File: rtl/mem_router.sv
// Memory-control decode: store steering to IMEM/DMEM, M-stage load selects,
// a handshaked MMIO port with timeout, pipeline stall and a sticky fault register.
module mem_router #(
  parameter int          ADDR_W       = 32,
  parameter int          STRB_W       = 4,
  parameter int          RGN_W        = 4,
  parameter logic [3:0]  RGN_DMEM     = 4'b0001,
  parameter logic [3:0]  RGN_IMEM     = 4'b0010,
  parameter logic [3:0]  RGN_BOTH     = 4'b0011,
  parameter logic [3:0]  RGN_BIOS     = 4'b0100,
  parameter logic [3:0]  RGN_IO       = 4'b1000,
  parameter int          IMEM_WR_GATE = 1,
  parameter int          IO_TIMEOUT   = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_router_if.slave    bus,
  output logic [1:0]     o_dbg_state
);

  localparam int OFF_W = (STRB_W > 1) ? $clog2(STRB_W) : 1;
  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [RGN_W-1:0]  w_drgn;
  logic [RGN_W-1:0]  w_prgn;
  logic [OFF_W-1:0]  w_off;
  logic              w_store;
  logic              w_acc;
  logic [STRB_W-1:0] w_m1;
  logic [STRB_W-1:0] w_m2;
  logic              w_m2_ok;
  logic              w_st_ok;
  logic              w_mis;
  logic              w_known;
  logic              w_unm;
  logic              w_bad;
  logic              w_gate;
  logic              w_stall;
  logic              w_trig;
  logic              w_to;

  logic [RGN_W-1:0]  r_prgn_m;
  logic [RGN_W-1:0]  r_drgn_m;
  logic              r_io_req;
  logic [STRB_W-1:0] r_io_we;
  logic [ADDR_W-1:0] r_io_adr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fault;
  logic [1:0]        r_cause;

  assign w_drgn  = bus.data_adr_e[ADDR_W-1 -: RGN_W];
  assign w_prgn  = bus.pc_e[ADDR_W-1 -: RGN_W];
  assign w_off   = bus.data_adr_e[OFF_W-1:0];
  assign w_store = |bus.wea;
  assign w_acc   = w_store | bus.rd_e;

  // A store must be exactly a byte, a halfword or a full word run starting at the offset.
  assign w_m1    = STRB_W'(1) << w_off;
  assign w_m2    = STRB_W'(3) << w_off;
  assign w_m2_ok = (w_off <= OFF_W'(STRB_W - 2));
  assign w_st_ok = (bus.wea == w_m1) || (w_m2_ok && (bus.wea == w_m2)) ||
                   ((w_off == '0) && (&bus.wea));
  assign w_mis   = (w_store && !w_st_ok) || (bus.rd_e && (w_off != '0));

  assign w_known = (w_drgn == RGN_DMEM) || (w_drgn == RGN_IMEM) ||
                   (w_drgn == RGN_BOTH) || (w_drgn == RGN_BIOS) ||
                   (w_drgn == RGN_IO);
  assign w_unm   = (w_acc && !w_known) || (bus.rd_e && (w_drgn == RGN_IMEM));
  assign w_bad   = w_mis || w_unm;
  assign w_gate  = (IMEM_WR_GATE == 0) || (w_prgn == RGN_BIOS);

  always_comb begin
    bus.iwea = '0;
    bus.dwea = '0;
    if (!w_stall && !w_bad) begin
      if ((w_drgn == RGN_DMEM) || (w_drgn == RGN_BOTH)) bus.dwea = bus.wea;
      if (((w_drgn == RGN_IMEM) || (w_drgn == RGN_BOTH)) && w_gate) bus.iwea = bus.wea;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // rst_n gates the trigger so stall drops the instant reset is applied.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_trig  = 1'b0;
    w_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && (w_drgn == RGN_IO) && w_acc && !w_mis) begin
          w_trig  = 1'b1;
          w_stall = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (bus.io_ack) begin
          w_next = S_WAIT1;
        end else if (r_cnt == CNT_W'(IO_TIMEOUT)) begin
          w_to   = 1'b1;
          w_next = S_WAIT1;
        end
      end
      S_WAIT1: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_req <= 1'b0;
      r_io_we  <= '0;
      r_io_adr <= '0;
      r_cnt    <= '0;
    end else if (w_trig) begin
      r_io_req <= 1'b1;
      r_io_we  <= bus.wea;
      r_io_adr <= bus.data_adr_e;
      r_cnt    <= '0;
    end else if (r_state == S_REQ) begin
      if (w_next != S_REQ) r_io_req <= 1'b0;
      else                 r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
      r_cause <= 2'd0;
    end else if (bus.fault_clr) begin
      r_fault <= 1'b0;
      r_cause <= 2'd0;
    end else if (!r_fault && (w_to || w_bad)) begin
      r_fault <= 1'b1;
      r_cause <= w_to ? 2'd3 : (w_mis ? 2'd2 : 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prgn_m <= '0;
      r_drgn_m <= '0;
    end else if (!w_stall) begin
      r_prgn_m <= w_prgn;
      r_drgn_m <= w_drgn;
    end
  end

  always_comb begin
    bus.dload_sel = 2'd0;
    if (r_drgn_m == RGN_BIOS)    bus.dload_sel = 2'd1;
    else if (r_drgn_m == RGN_IO) bus.dload_sel = 2'd2;
  end

  assign bus.iload_sel   = (r_prgn_m == RGN_BIOS);
  assign bus.io_req      = r_io_req;
  assign bus.io_we       = r_io_we;
  assign bus.io_adr      = r_io_adr;
  assign bus.stall       = w_stall;
  assign bus.fault       = r_fault;
  assign bus.fault_cause = r_cause;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: steering, selects, MMIO handshake/timeout,
// fault register and reset in the middle of an MMIO transaction.
module tb_mem_router;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];

  mem_router_if #(.ADDR_W(32), .STRB_W(4)) bus ();

  mem_router #(.IO_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] adr,
                       input logic [3:0] we, input logic rd);
    bus.pc_e       = pc;
    bus.data_adr_e = adr;
    bus.wea        = we;
    bus.rd_e       = rd;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.io_ack = 1'b0;
    bus.fault_clr = 1'b0;
    drive(32'h0, 32'h0, 4'b0000, 1'b0);
    repeat (2) tick();
    chk("rst_io_req", bus.io_req, 0);
    chk("rst_stall", bus.stall, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_iload_sel", bus.iload_sel, 0);
    chk("rst_dload_sel", bus.dload_sel, 0);
    chk("rst_io_we", bus.io_we, 0);
    chk("rst_io_adr", bus.io_adr, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_cause", bus.fault_cause, 0);
    chk("rst_state", dbg_state, 0);

    // IMEM store gated by BIOS PC
    drive(32'h4000_0000, 32'h2000_0010, 4'b1111, 1'b0);
    chk("imem_gate_iwea", bus.iwea, 4'b1111);
    chk("imem_gate_dwea", bus.dwea, 4'b0000);
    drive(32'h1000_0000, 32'h2000_0010, 4'b1111, 1'b0);
    chk("imem_nogate_iwea", bus.iwea, 4'b0000);

    // BIOS load then BOTH store/load
    drive(32'h4000_0000, 32'h4000_0008, 4'b0000, 1'b1);
    tick();
    chk("bios_dload_sel", bus.dload_sel, 1);
    chk("bios_iload_sel", bus.iload_sel, 1);
    drive(32'h4000_0000, 32'h3000_0004, 4'b0011, 1'b0);
    chk("both_iwea", bus.iwea, 4'b0011);
    chk("both_dwea", bus.dwea, 4'b0011);
    tick();
    drive(32'h4000_0000, 32'h3000_0004, 4'b0000, 1'b1);
    chk("both_dload_sel", bus.dload_sel, 0);
    chk("both_fault", bus.fault, 0);

    // MMIO load acked on the 4th REQ cycle
    drive(32'h1000_0000, 32'h8000_0000, 4'b0000, 1'b1);
    exp_q.push_back(32'h8000_0000);
    chk("io_trig_stall", bus.stall, 1);
    chk("io_trig_state", dbg_state, 0);
    tick();
    chk("io_req_c1", bus.io_req, 1);
    chk("io_adr", bus.io_adr, exp_q.pop_front());
    chk("io_we_load", bus.io_we, 0);
    chk("io_stall_c1", bus.stall, 1);
    tick();
    chk("io_req_c2", bus.io_req, 1);
    tick();
    chk("io_req_c3", bus.io_req, 1);
    tick();
    bus.io_ack = 1'b1;
    #1;
    chk("io_req_c4", bus.io_req, 1);
    chk("io_stall_c4", bus.stall, 1);
    tick();
    bus.io_ack = 1'b0;
    #1;
    chk("io_wait1_req", bus.io_req, 0);
    chk("io_wait1_stall", bus.stall, 0);
    chk("io_wait1_state", dbg_state, 2);
    tick();
    drive(32'h1000_0000, 32'h1000_0000, 4'b0000, 1'b0);
    chk("io_dload_sel", bus.dload_sel, 2);
    chk("io_iload_sel", bus.iload_sel, 0);
    chk("io_back_idle", dbg_state, 0);
    chk("io_ok_fault", bus.fault, 0);

    // MMIO store with no ack: timeout after 9 REQ cycles
    drive(32'h1000_0000, 32'h8000_0010, 4'b1111, 1'b0);
    exp_q.push_back(32'h8000_0010);
    chk("to_trig_stall", bus.stall, 1);
    tick();
    chk("to_io_we", bus.io_we, 4'b1111);
    chk("to_io_adr", bus.io_adr, exp_q.pop_front());
    chk("to_req_c1", bus.io_req, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("to_req_c%0d", i + 2), bus.io_req, 1);
    end
    chk("to_nofault_yet", bus.fault, 0);
    tick();
    chk("to_req_drop", bus.io_req, 0);
    chk("to_fault", bus.fault, 1);
    chk("to_cause", bus.fault_cause, 3);
    chk("to_wait1_stall", bus.stall, 0);
    drive(32'h1000_0000, 32'h1000_0000, 4'b0000, 1'b0);
    tick();
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("to_clr_fault", bus.fault, 0);
    chk("to_clr_cause", bus.fault_cause, 0);

    // Misaligned store, clear priority, sticky cause
    drive(32'h1000_0000, 32'h1000_0002, 4'b1100, 1'b0);
    chk("half_off2_dwea", bus.dwea, 4'b1100);
    drive(32'h1000_0000, 32'h1000_0000, 4'b0110, 1'b0);
    chk("mis_dwea", bus.dwea, 4'b0000);
    tick();
    chk("mis_fault", bus.fault, 1);
    chk("mis_cause", bus.fault_cause, 2);
    drive(32'h1000_0000, 32'h5000_0000, 4'b0000, 1'b1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("clr_prio_fault", bus.fault, 0);
    chk("clr_prio_cause", bus.fault_cause, 0);
    tick();
    chk("unm_fault", bus.fault, 1);
    chk("unm_cause", bus.fault_cause, 1);
    drive(32'h1000_0000, 32'h1000_0002, 4'b0000, 1'b1);
    tick();
    chk("sticky_cause", bus.fault_cause, 1);
    drive(32'h1000_0000, 32'h1000_0000, 4'b0000, 1'b0);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    drive(32'h1000_0000, 32'h2000_0000, 4'b0000, 1'b1);
    tick();
    chk("imem_load_fault", bus.fault, 1);
    chk("imem_load_cause", bus.fault_cause, 1);
    drive(32'h1000_0000, 32'h1000_0000, 4'b0000, 1'b0);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;

    // Reset while in REQ
    drive(32'h4000_0000, 32'h4000_0000, 4'b0000, 1'b1);
    tick();
    drive(32'h1000_0000, 32'h8000_0020, 4'b0000, 1'b1);
    tick();
    chk("rr_req", bus.io_req, 1);
    chk("rr_dload_hold", bus.dload_sel, 1);
    tick();
    #1;
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 4'b0000, 1'b0);
    chk("rr_io_req", bus.io_req, 0);
    chk("rr_stall", bus.stall, 0);
    chk("rr_dload_sel", bus.dload_sel, 0);
    chk("rr_state", dbg_state, 0);
    #2;
    rst_n = 1'b1;
    tick();
    bus.io_ack = 1'b1;
    tick();
    bus.io_ack = 1'b0;
    #1;
    chk("rr_ack_state", dbg_state, 0);
    chk("rr_ack_req", bus.io_req, 0);
    chk("rr_ack_stall", bus.stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_router.md
Name: mem_router

Overview:
- Parametrised successor to the core's memory-control decode.
- Steers store byte-enables to IMEM/DMEM, and registers load-return selects into the M stage.
- Adds a handshaked MMIO port with a wait-state and timeout state machine, a pipeline stall output, and a sticky fault register for unmapped or misaligned accesses.
- Sits between the E/M pipeline boundary and the IMEM, DMEM, BIOS and IO blocks.

Parameters:
- ADDR_W, 32: PC and data-address width.
- STRB_W, 4: byte-enable width; word = 8*STRB_W bits.
- RGN_W, 4: region field width, taken from the MSBs of the address.
- RGN_DMEM, 4'b0001: DMEM read/write region.
- RGN_IMEM, 4'b0010: IMEM write-only region.
- RGN_BOTH, 4'b0011: IMEM write plus DMEM read/write region.
- RGN_BIOS, 4'b0100: BIOS fetch/read region.
- RGN_IO, 4'b1000: MMIO region.
- IMEM_WR_GATE, 1: if 1, IMEM writes only when pc_e region equals RGN_BIOS.
- IO_TIMEOUT, 255: max cycles waiting for io_ack; counter width = clog2(IO_TIMEOUT+1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc_e  in  ADDR_W  E-stage PC
- data_adr_e  in  ADDR_W  E-stage data address
- wea  in  STRB_W  E-stage store byte-enables, pre-shifted; nonzero means store
- rd_e  in  1  E-stage load valid
- iwea  out  STRB_W  IMEM write enables (combinational)
- dwea  out  STRB_W  DMEM write enables (combinational)
- iload_sel  out  1  M-stage fetch select: 0 = IMEM, 1 = BIOS
- dload_sel  out  2  M-stage data select: 0 = DMEM, 1 = BIOS, 2 = IO
- io_req  out  1  MMIO request, held until ack
- io_we  out  STRB_W  MMIO byte-enables, registered with the request
- io_adr  out  ADDR_W  MMIO address, registered
- io_ack  in  1  MMIO completion strobe
- stall  out  1  freeze E and M pipeline registers
- fault  out  1  sticky fault flag
- fault_cause  out  2  1 = unmapped, 2 = misaligned, 3 = IO timeout
- fault_clr  in  1  synchronous clear of fault and fault_cause

Behaviour:
- Reset (rst_n low, async): the following clear to 0.
  - iload_sel, dload_sel, io_req, io_we, io_adr.
  - fault, fault_cause, M-stage region registers, timeout counter.
  - FSM goes to IDLE.
- Reset mid-IO-transaction drops io_req immediately. A later io_ack is ignored.
- Store steering, combinational on E-stage data region:
  - DMEM or BOTH: dwea = wea.
  - IMEM or BOTH: iwea = wea only if the gate passes (IMEM_WR_GATE = 0, or pc_e region == RGN_BIOS).
  - Otherwise iwea = dwea = 0.
  - Both forced to 0 while stall = 1, or when the access is flagged misaligned.
- Misaligned: wea has a nonzero bit outside the contiguous run of 1, 2 or STRB_W bytes starting at data_adr_e[1:0]; or rd_e with any address whose low bits are not valid for a word load. Loads use the word-align check only (sub-word alignment is handled elsewhere).
- Unmapped: a store or load (wea != 0 or rd_e) whose region is none of the five codes, or a load to RGN_IMEM.
- M-stage selects: E-stage regions are registered each cycle unless stall = 1 (hold). Values are one cycle after E:
  - iload_sel = 1 iff the registered PC region == RGN_BIOS, else 0.
  - dload_sel: DMEM/BOTH → 0, BIOS → 1, IO → 2, else 0.
- IO FSM, states IDLE, REQ, WAIT1:
  - IDLE → REQ when the data region == RGN_IO and (wea != 0 or rd_e) and not misaligned. Same edge: io_req = 1, io_adr = data_adr_e, io_we = wea.
  - stall is combinationally 1 in the IDLE cycle that triggers, and throughout REQ.
  - REQ: count up each cycle. When io_ack = 1, go to WAIT1 and drop io_req.
  - REQ: if count == IO_TIMEOUT and no ack, raise fault with cause 3, drop io_req, go to WAIT1.
  - WAIT1: stall = 0 for one cycle so the core advances (the M-stage read of IO data happens here); then IDLE. A new IO request is not accepted in WAIT1.
  - io_ack in IDLE or WAIT1 is ignored.
- Fault register:
  - Set on the first detected fault; cause is captured, later faults do not overwrite.
  - fault_clr has priority over a simultaneous new fault (the new one is dropped).
  - A faulting access never reaches any memory.

Test Plan:
- pc_e = 0x4000_0000, data_adr_e = 0x2000_0010, wea = 4'b1111 → iwea = 4'b1111, dwea = 0. Same with pc_e = 0x1000_0000 → iwea = 0.
- data_adr_e = 0x3000_0004, wea = 4'b0011, pc in BIOS → iwea = dwea = 4'b0011. Next cycle, with rd_e, dload_sel = 0.
- IO load to 0x8000_0000, io_ack after 3 cycles → io_req high 4 cycles, stall high for the trigger plus 4 REQ cycles, then low; dload_sel = 2.
- IO request, io_ack never asserted, IO_TIMEOUT = 8 → fault = 1, fault_cause = 3, io_req low after 9 REQ cycles.
- Store wea = 4'b0110 at address offset 0 → fault_cause = 2, dwea = 0. Then fault_clr together with an unmapped access 0x5000_0000 → fault = 0.
- Assert rst_n = 0 while in REQ → io_req, stall, dload_sel = 0 immediately. After release, an io_ack pulse causes no transition.
